div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin controller that shares one signed 32-bit `DIV` unit between two requesters. It latches a granted requester's operands and sequences the divider's `start`/`busy` handshake. It returns quotient and remainder on a shared result bus with a per-requester `done` pulse. Divide-by-zero and the `0x80000000 / -1` overflow are resolved locally without occupying the divider, and a watchdog aborts a hung division.

## Interface
- `TIMEOUT`, default 40: maximum cycles spent in WAIT before abort; must be 2..255.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req0`, `req1`  in  1: request level from each requester; held high with operands stable until the matching `done`.
- `dividend0`, `dividend1`  in  32: signed dividend per requester.
- `divisor0`, `divisor1`  in  32: signed divisor per requester.
- `done0`, `done1`  out  1: one-cycle completion pulse to the granted requester.
- `q`  out  32: quotient, valid while a `done` is high.
- `r`  out  32: remainder, valid while a `done` is high.
- `dz`  out  1: divide-by-zero flag, valid with `done`.
- `err`  out  1: watchdog abort flag, valid with `done`.
- `div_dividend`, `div_divisor`  out  32: registered operands driven to the DIV unit.
- `div_start`  out  1: one-cycle start pulse to the DIV unit.
- `div_q`, `div_r`  in  32: DIV unit results.
- `div_busy`  in  1: DIV unit busy.

## Operation
- States:
  - IDLE: sample requests and arbitrate.
  - ISSUE: `div_start`=1.
  - ARM: one dead cycle so `busy` can rise.
  - WAIT: wait for `div_busy`=0 or the watchdog.
  - RESP: pulse `done`.
- Arbitration in IDLE:
  - If only one `req` is high, grant it.
  - If both are high, grant the requester that was not granted last.
  - Register `last` updates on grant; reset value 1, so `req0` wins the first tie.
- On grant, latch the granted operands and id into internal registers. Later changes on the request inputs are ignored until RESP.
- Bypass, checked on the latched operands in the grant cycle; next state is RESP directly:
  - Divisor == 0: `q`=32'hFFFFFFFF, `r`=dividend, `dz`=1.
  - Dividend == 32'h80000000 and divisor == 32'hFFFFFFFF: `q`=32'h80000000, `r`=0.
- Otherwise the sequence is IDLE → ISSUE → ARM → WAIT.
- WAIT:
  - A counter starts at 0 on entry and increments each WAIT cycle.
  - If `div_busy`=0, capture `div_q`/`div_r` into `q`/`r` and go to RESP.
  - If instead the counter reaches `TIMEOUT`-1, set `q`=`r`=0 and `err`=1, then go to RESP.
  - If `div_busy` falls in that same final cycle, the result is captured and `err`=0 (the result wins).
- RESP: assert `done` of the latched id for exactly one cycle, then return to IDLE.
- `q`, `r`, `dz` and `err` hold their values until the next RESP. `dz`/`err` are cleared at every grant.
- Widths: all arithmetic is 32-bit two's complement. No sign or extension logic lives here; DIV does the division.

## Timing
- Reset (asynchronous, active-low) forces:
  - state=IDLE, `last`=1, counter=0;
  - `done0`/`done1`/`div_start`/`dz`/`err`=0;
  - `q`/`r`/`div_dividend`/`div_divisor`=0.
- Reset mid-operation abandons the job with no `done`. The DIV unit is reset separately by the system.
- Normal path, with cycle 0 = IDLE cycle in which `req` is sampled high:
  - cycle 1: ISSUE, `div_start`=1;
  - cycle 2: ARM;
  - cycle 3 onward: WAIT;
  - RESP occurs the cycle after `div_busy` is seen low in WAIT.
- Bypass path: `done` in cycle 1.
- `div_dividend`/`div_divisor` are stable from ISSUE through WAIT.
- Requester handshake:
  - The requester drops `req` on the clock edge that ends its `done` cycle.
  - If `req` is still high in the following IDLE cycle, it is treated as a new request.
- Back-to-back jobs: IDLE sits one cycle between RESP and the next ISSUE. Minimum turnaround is 2 cycles for bypass and 4 + DIV latency for a real division.
- `done0` and `done1` are never high in the same cycle.

## Test plan
- `req0` alone, 4464 / 1 → `div_start` pulse at cycle 1; `done0` after `busy` falls with `q`=4464, `r`=0, `dz`=0, `err`=0.
- `req1` alone, 4464 / 0 → no `div_start`; `done1` in cycle 1 with `q`=32'hFFFFFFFF, `r`=4464, `dz`=1.
- `req0` alone, 32'h80000000 / 32'hFFFFFFFF → bypass; `q`=32'h80000000, `r`=0, `done0` in cycle 1.
- `req0` and `req1` held high continuously with 32'h7FFFFFFF / 32 and 32'h8FFFFFFF / -5 →
  - grants alternate 0,1,0,1;
  - results are `q`=0x03FFFFFF, `r`=31 and `q`=0x16666666, `r`=-3 respectively.
- DIV model holding `busy` high forever, `TIMEOUT`=40 → `done` 40 WAIT cycles after entry with `err`=1, `q`=`r`=0; the next request is served normally.
- `reset` low during WAIT → all outputs 0 immediately; no `done`; after release, `req1` and `req0` both high → `req0` granted first.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one signed 32-bit DIV unit between two
// requesters. Divide-by-zero and the most-negative / -1 overflow are answered
// locally. A watchdog aborts a division whose busy never falls.
module div_arbiter #(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] dividend0,
  input  logic [31:0] dividend1,
  input  logic [31:0] divisor0,
  input  logic [31:0] divisor1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        dz,
  output logic        err,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_start,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             state;
  logic               last;
  logic               id;
  logic [7:0]         cnt;

  logic               gnt_id;
  logic signed [31:0] sel_dvd;
  logic signed [31:0] sel_dvs;

  // A zero divisor never reaches the DIV unit.
  function automatic logic is_div_zero(input logic signed [31:0] dvs);
    return dvs == 32'sd0;
  endfunction

  // The only quotient that does not fit in 32 bits: most-negative / -1.
  function automatic logic is_ovf(input logic signed [31:0] dvd,
                                  input logic signed [31:0] dvs);
    return (dvd == 32'sh8000_0000) && (dvs == -32'sd1);
  endfunction

  // Round-robin pick: a tie goes to the requester not served last.
  always_comb begin
    gnt_id  = (req0 && req1) ? ~last : req1;
    sel_dvd = gnt_id ? dividend1 : dividend0;
    sel_dvs = gnt_id ? divisor1  : divisor0;
  end

  // Arbitration, DIV handshake sequencing, watchdog and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last         <= 1'b1;
      id           <= 1'b0;
      cnt          <= 8'd0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      div_start    <= 1'b0;
      dz           <= 1'b0;
      err          <= 1'b0;
      q            <= 32'd0;
      r            <= 32'd0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
    end else begin
      done0     <= 1'b0;
      done1     <= 1'b0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            last         <= gnt_id;
            id           <= gnt_id;
            div_dividend <= sel_dvd;
            div_divisor  <= sel_dvs;
            dz           <= 1'b0;
            err          <= 1'b0;
            if (is_div_zero(sel_dvs)) begin
              q     <= 32'hFFFF_FFFF;
              r     <= sel_dvd;
              dz    <= 1'b1;
              done0 <= ~gnt_id;
              done1 <= gnt_id;
              state <= RESP;
            end else if (is_ovf(sel_dvd, sel_dvs)) begin
              q     <= 32'h8000_0000;
              r     <= 32'd0;
              done0 <= ~gnt_id;
              done1 <= gnt_id;
              state <= RESP;
            end else begin
              div_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: state <= ARM;
        ARM: begin
          cnt   <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving in the final watchdog cycle still wins.
          if (!div_busy) begin
            q     <= div_q;
            r     <= div_r;
            done0 <= ~id;
            done1 <= id;
            state <= RESP;
          end else if (cnt == CNT_LAST) begin
            q     <= 32'd0;
            r     <= 32'd0;
            err   <= 1'b1;
            done0 <= ~id;
            done1 <= id;
            state <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: a DIV unit stub with programmable latency/hang,
// requesters driven from tables or $urandom, and a cycle-timeline model.
module tb_div_arbiter;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] dvd [2];
  logic [31:0] dvs [2];
  logic        done0, done1, dz, err, div_start, div_busy;
  logic [31:0] q, r, div_dividend, div_divisor, div_q, div_r;

  div_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req0(req[0]), .req1(req[1]),
    .dividend0(dvd[0]), .dividend1(dvd[1]),
    .divisor0(dvs[0]), .divisor1(dvs[1]),
    .done0(done0), .done1(done1), .q(q), .r(r), .dz(dz), .err(err),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_start(div_start), .div_q(div_q), .div_r(div_r), .div_busy(div_busy)
  );

  always #5 clock = ~clock;

  // DIV unit stub: busy for lat_cfg cycles after start, or forever if hang_cfg.
  int          lat_cfg = 3;
  logic        hang_cfg = 1'b0;
  int          s_cnt;
  logic        s_hang;
  logic [31:0] s_q, s_r;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_busy <= 1'b0; div_q <= 32'd0; div_r <= 32'd0;
      s_cnt <= 0; s_hang <= 1'b0; s_q <= 32'd0; s_r <= 32'd0;
    end else if (div_start) begin
      div_busy <= 1'b1; s_cnt <= lat_cfg; s_hang <= hang_cfg;
      div_q <= 32'hDEAD_BEEF; div_r <= 32'hBAD0_BAD0;
      if (div_divisor == 32'd0) begin
        s_q <= 32'hFFFF_FFFF; s_r <= div_dividend;
      end else if (div_divisor == 32'hFFFF_FFFF) begin
        s_q <= -div_dividend; s_r <= 32'd0;
      end else begin
        s_q <= 32'($signed(div_dividend) / $signed(div_divisor));
        s_r <= 32'($signed(div_dividend) % $signed(div_divisor));
      end
    end else if (div_busy && !s_hang) begin
      if (s_cnt <= 1) begin
        div_busy <= 1'b0; div_q <= s_q; div_r <= s_r;
      end
      s_cnt <= s_cnt - 1;
    end
  end

  int checks = 0;
  int errors = 0;

  // Model state: a timeline of the current job in absolute cycle numbers.
  int          cyc = 0;
  int          free_from = 0;
  int          g = 0;
  int          dcyc = -1;
  bit          act = 1'b0;
  bit          byp = 1'b0;
  bit          mlast = 1'b1;
  bit          mid = 1'b0;
  logic [31:0] ea, eb, eq, er;
  logic        edz, eerr;

  // Observations and requester controls.
  int          start_cyc = -1;
  int          done_obs_cyc = 0;
  int          raise_cyc [2];
  logic [31:0] got_q [2];
  logic [31:0] got_r [2];
  logic        got_dz [2];
  logic        got_err [2];
  int          order [$];
  int          want [2];
  bit          rnd = 1'b0;
  logic [31:0] fa [2];
  logic [31:0] fb [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Truncating signed division; remainder derived from the quotient.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] qq, output logic [31:0] rr);
    int sa, sb, sq;
    sa = a; sb = b;
    sq = sa / sb;
    qq = sq;
    rr = sa - sq * sb;
  endtask

  task automatic rand_ops(output logic [31:0] a, output logic [31:0] b);
    a = $urandom;
    case ($urandom_range(0, 9))
      0: b = 32'd0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2, 3: begin
        b = $urandom_range(1, 9);
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      default: b = $urandom;
    endcase
  endtask

  // One clock: check this cycle, drive the next inputs, advance the model.
  task automatic step();
    logic e0, e1, es, d;
    logic [31:0] a, b;
    @(negedge clock);
    cyc++;
    e0 = act && (cyc == dcyc) && !mid;
    e1 = act && (cyc == dcyc) && mid;
    es = act && !byp && (cyc == g + 1);
    chk("done0", 32'(done0), 32'(e0));
    chk("done1", 32'(done1), 32'(e1));
    chk("div_start", 32'(div_start), 32'(es));
    if (act && !byp && cyc > g && (dcyc < 0 || cyc < dcyc)) begin
      chk("div_dividend", div_dividend, ea);
      chk("div_divisor", div_divisor, eb);
    end
    if (act && cyc == dcyc) begin
      chk("q", q, eq);
      chk("r", r, er);
      chk("dz", 32'(dz), 32'(edz));
      chk("err", 32'(err), 32'(eerr));
      act = 1'b0;
      free_from = cyc + 1;
    end
    if (div_start) start_cyc = cyc;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? done0 : done1;
      if (d && req[i]) begin
        got_q[i] = q; got_r[i] = r; got_dz[i] = dz; got_err[i] = err;
        order.push_back(i);
        done_obs_cyc = cyc;
        req[i] = 1'b0;
        if (want[i] > 0) want[i]--;
      end
      if (!req[i] && want[i] > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
        if (rnd) rand_ops(a, b);
        else begin a = fa[i]; b = fb[i]; end
        dvd[i] = a; dvs[i] = b; req[i] = 1'b1;
        raise_cyc[i] = cyc;
      end
    end
    if (rnd) begin
      lat_cfg  = ($urandom_range(0, 9) == 0) ? $urandom_range(38, 42) : $urandom_range(1, 8);
      hang_cfg = ($urandom_range(0, 29) == 0);
    end
    if (!act && cyc >= free_from && req != 2'b00) begin
      mid = (req == 2'b11) ? !mlast : req[1];
      mlast = mid;
      ea = dvd[mid]; eb = dvs[mid];
      act = 1'b1; g = cyc; edz = 1'b0; eerr = 1'b0;
      if (eb == 32'd0) begin
        byp = 1'b1; eq = 32'hFFFF_FFFF; er = ea; edz = 1'b1; dcyc = cyc + 1;
      end else if (ea == 32'h8000_0000 && eb == 32'hFFFF_FFFF) begin
        byp = 1'b1; eq = 32'h8000_0000; er = 32'd0; dcyc = cyc + 1;
      end else begin
        byp = 1'b0; dcyc = -1;
      end
    end else if (act && !byp && dcyc < 0 && cyc >= g + 3) begin
      if (!div_busy) begin
        ref_div(ea, eb, eq, er);
        dcyc = cyc + 1;
      end else if (cyc == g + 2 + TIMEOUT) begin
        eq = 32'd0; er = 32'd0; eerr = 1'b1; dcyc = cyc + 1;
      end
    end
  endtask

  task automatic run_until_idle(input int max);
    for (int k = 0; k < max; k++) begin
      if (want[0] == 0 && want[1] == 0 && req == 2'b00 && !act) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL idle_wait got still-busy expected idle within %0d cycles", max);
  endtask

  task automatic job(input int i, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic hang);
    fa[i] = a; fb[i] = b; lat_cfg = lat; hang_cfg = hang;
    want[i] = 1; start_cyc = -1;
    run_until_idle(200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b0;
    req = 2'b00;
    want[0] = 0; want[1] = 0;
    for (int i = 0; i < 2; i++) begin
      dvd[i] = 32'd0; dvs[i] = 32'd0; fa[i] = 32'd0; fb[i] = 32'd0; raise_cyc[i] = 0;
    end
    #2;
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_dz_err", {30'd0, dz, err}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Plain division through the DIV unit.
    job(0, 32'd4464, 32'd1, 3, 1'b0);
    chk("t1_q", got_q[0], 32'd4464);
    chk("t1_r", got_r[0], 32'd0);
    chk("t1_dz_err", {30'd0, got_dz[0], got_err[0]}, 32'd0);
    chk("t1_start_at", 32'(start_cyc - raise_cyc[0]), 32'd1);
    chk("t1_done_at", 32'(done_obs_cyc - start_cyc), 32'd5);

    // Overflow bypass.
    job(0, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b0);
    chk("t3_q", got_q[0], 32'h8000_0000);
    chk("t3_r", got_r[0], 32'd0);
    chk("t3_no_start", 32'(start_cyc), 32'hFFFF_FFFF);
    chk("t3_done_at", 32'(done_obs_cyc - raise_cyc[0]), 32'd1);

    // Divide-by-zero bypass on requester 1.
    job(1, 32'd4464, 32'd0, 3, 1'b0);
    chk("t2_q", got_q[1], 32'hFFFF_FFFF);
    chk("t2_r", got_r[1], 32'd4464);
    chk("t2_dz", 32'(got_dz[1]), 32'd1);
    chk("t2_no_start", 32'(start_cyc), 32'hFFFF_FFFF);
    chk("t2_done_at", 32'(done_obs_cyc - raise_cyc[1]), 32'd1);

    // Both requests held high: grants must alternate.
    fa[0] = 32'h7FFF_FFFF; fb[0] = 32'd32;
    fa[1] = 32'h8FFF_FFFF; fb[1] = 32'hFFFF_FFFB;
    lat_cfg = 2; hang_cfg = 1'b0;
    order.delete();
    want[0] = 2; want[1] = 2;
    run_until_idle(300);
    chk("t4_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("t4_grant0", 32'(order[0]), 32'd0);
      chk("t4_grant1", 32'(order[1]), 32'd1);
      chk("t4_grant2", 32'(order[2]), 32'd0);
      chk("t4_grant3", 32'(order[3]), 32'd1);
    end
    chk("t4_q0", got_q[0], 32'h03FF_FFFF);
    chk("t4_r0", got_r[0], 32'd31);
    chk("t4_q1", got_q[1], 32'h1666_6666);
    chk("t4_r1", got_r[1], 32'hFFFF_FFFD);

    // busy falls in the last watchdog cycle: result wins.
    job(1, 32'hFFFF_FF9C, 32'd7, 40, 1'b0);
    chk("edge_err", 32'(got_err[1]), 32'd0);
    chk("edge_q", got_q[1], 32'hFFFF_FFF2);
    chk("edge_r", got_r[1], 32'hFFFF_FFFE);
    chk("edge_done_at", 32'(done_obs_cyc - start_cyc), 32'd42);

    // One cycle later is an abort.
    job(1, 32'hFFFF_FF9C, 32'd7, 41, 1'b0);
    chk("late_err", 32'(got_err[1]), 32'd1);
    chk("late_q", got_q[1], 32'd0);

    // Hung DIV unit: watchdog, then normal service resumes.
    job(0, 32'd100, 32'd7, 3, 1'b1);
    chk("t5_err", 32'(got_err[0]), 32'd1);
    chk("t5_q", got_q[0], 32'd0);
    chk("t5_r", got_r[0], 32'd0);
    chk("t5_done_at", 32'(done_obs_cyc - start_cyc), 32'd42);
    job(0, 32'd100, 32'd7, 3, 1'b0);
    chk("t5b_q", got_q[0], 32'd14);
    chk("t5b_r", got_r[0], 32'd2);
    chk("t5b_err", 32'(got_err[0]), 32'd0);

    // Reset during WAIT.
    fa[0] = 32'd5; fb[0] = 32'd3; lat_cfg = 3; hang_cfg = 1'b1;
    want[0] = 1;
    for (int k = 0; k < 8; k++) step();
    reset = 1'b0;
    #1;
    chk("mid_rst_done", {30'd0, done0, done1}, 32'd0);
    chk("mid_rst_start", 32'(div_start), 32'd0);
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_r", r, 32'd0);
    chk("mid_rst_dz_err", {30'd0, dz, err}, 32'd0);
    chk("mid_rst_dvd", div_dividend, 32'd0);
    chk("mid_rst_dvs", div_divisor, 32'd0);
    act = 1'b0; mlast = 1'b1; free_from = 0; dcyc = -1;
    req = 2'b00; want[0] = 0; want[1] = 0; hang_cfg = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    fa[0] = 32'd9; fb[0] = 32'd2; fa[1] = 32'd9; fb[1] = 32'd4; lat_cfg = 2;
    order.delete();
    want[0] = 1; want[1] = 1;
    run_until_idle(200);
    chk("t6_count", 32'(order.size()), 32'd2);
    if (order.size() > 0) chk("t6_first", 32'(order[0]), 32'd0);
    chk("t6_q0", got_q[0], 32'd4);
    chk("t6_q1", got_q[1], 32'd2);

    // Randomized traffic against the model.
    rnd = 1'b1;
    want[0] = 120; want[1] = 120;
    run_until_idle(20000);
    rnd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
